// File: rtl/rectifier_adc_sequencer.sv
// Periodic acquisition sequencer for the two AD7822 converters (battery current and voltage)
// that share one 8-bit data bus: convert-start, EOC wait with timeout, then one read per device.
module rectifier_adc_sequencer #(
    parameter int SAMPLE_DIV  = 100,
    parameter int CONVST_W    = 2,
    parameter int RD_W        = 3,
    parameter int EOC_TIMEOUT = 50
) (
    input  logic       i_CLK,
    input  logic       i_RST_n,
    input  logic       i_enable,
    input  logic       i_err_clr,
    input  logic [7:0] i_ADC_DATA,
    input  logic       i_EOC_I_n,
    input  logic       i_EOC_V_n,
    output logic       o_CONVST_n,
    output logic       o_CS_I_n,
    output logic       o_CS_V_n,
    output logic       o_RD_n,
    output logic [7:0] o_Ibat_ADC,
    output logic [7:0] o_Vbat_ADC,
    output logic       o_valid_I,
    output logic       o_valid_V,
    output logic       o_timeout_err
);

    localparam int PER_W  = $clog2(SAMPLE_DIV + 1);
    localparam int TMO_W  = $clog2(EOC_TIMEOUT + 1);
    localparam int PH_MAX = (CONVST_W > RD_W) ? CONVST_W : RD_W;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SAMPLE_DIV - 1);
    localparam logic [PER_W-1:0] PER_MAX   = PER_W'(SAMPLE_DIV);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(EOC_TIMEOUT);
    localparam logic [PH_W-1:0]  CONV_LAST = PH_W'(CONVST_W - 1);
    localparam logic [PH_W-1:0]  RD_LAST   = PH_W'(RD_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_READ_I = 3'd3,
        ST_GAP    = 3'd4,
        ST_READ_V = 3'd5,
        ST_HOLD   = 3'd6
    } state_t;

    state_t           state_r;
    logic [PER_W-1:0] per_cnt_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [PH_W-1:0]  ph_cnt_r;
    logic             seen_i_r;
    logic             seen_v_r;
    logic             convst_n_r;
    logic             cs_i_n_r;
    logic             cs_v_n_r;
    logic             rd_n_r;
    logic [7:0]       ibat_r;
    logic [7:0]       vbat_r;
    logic             valid_i_r;
    logic             valid_v_r;
    logic             err_r;

    logic eoc_i_meta_r, eoc_i_sync_r, eoc_i_prev_r;
    logic eoc_v_meta_r, eoc_v_sync_r, eoc_v_prev_r;
    logic eoc_i_fall_s, eoc_v_fall_s;

    // Two-flop synchronisers for both EOC lines plus one history flop for edge detection
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            eoc_i_meta_r <= 1'b1;
            eoc_i_sync_r <= 1'b1;
            eoc_i_prev_r <= 1'b1;
            eoc_v_meta_r <= 1'b1;
            eoc_v_sync_r <= 1'b1;
            eoc_v_prev_r <= 1'b1;
        end else begin
            eoc_i_meta_r <= i_EOC_I_n;
            eoc_i_sync_r <= eoc_i_meta_r;
            eoc_i_prev_r <= eoc_i_sync_r;
            eoc_v_meta_r <= i_EOC_V_n;
            eoc_v_sync_r <= eoc_v_meta_r;
            eoc_v_prev_r <= eoc_v_sync_r;
        end
    end

    assign eoc_i_fall_s = eoc_i_prev_r & ~eoc_i_sync_r;
    assign eoc_v_fall_s = eoc_v_prev_r & ~eoc_v_sync_r;

    // Sequencer FSM; every bus strobe is a register updated together with the state it belongs to
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_r    <= ST_IDLE;
            per_cnt_r  <= {PER_W{1'b0}};
            tmo_cnt_r  <= {TMO_W{1'b0}};
            ph_cnt_r   <= {PH_W{1'b0}};
            seen_i_r   <= 1'b0;
            seen_v_r   <= 1'b0;
            convst_n_r <= 1'b1;
            cs_i_n_r   <= 1'b1;
            cs_v_n_r   <= 1'b1;
            rd_n_r     <= 1'b1;
            ibat_r     <= 8'h00;
            vbat_r     <= 8'h00;
            valid_i_r  <= 1'b0;
            valid_v_r  <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            valid_i_r <= 1'b0;
            valid_v_r <= 1'b0;
            per_cnt_r <= (per_cnt_r == PER_MAX) ? per_cnt_r : per_cnt_r + PER_W'(1);
            if (eoc_i_fall_s) seen_i_r <= 1'b1;
            if (eoc_v_fall_s) seen_v_r <= 1'b1;
            // A timeout assigned later in this block overrides the clear
            if (i_err_clr) err_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (i_enable) begin
                        state_r    <= ST_CONV;
                        convst_n_r <= 1'b0;
                        per_cnt_r  <= {PER_W{1'b0}};
                        ph_cnt_r   <= {PH_W{1'b0}};
                        seen_i_r   <= 1'b0;
                        seen_v_r   <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    if (ph_cnt_r == CONV_LAST) begin
                        state_r    <= ST_WAIT;
                        convst_n_r <= 1'b1;
                        tmo_cnt_r  <= {TMO_W{1'b0}};
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_W'(1);
                    end
                end
                ST_WAIT: begin
                    if ((seen_i_r && seen_v_r) || (tmo_cnt_r == TMO_LAST)) begin
                        if (!(seen_i_r && seen_v_r)) err_r <= 1'b1;
                        ph_cnt_r <= {PH_W{1'b0}};
                        if (seen_i_r) begin
                            state_r  <= ST_READ_I;
                            cs_i_n_r <= 1'b0;
                            rd_n_r   <= 1'b0;
                        end else if (seen_v_r) begin
                            state_r  <= ST_READ_V;
                            cs_v_n_r <= 1'b0;
                            rd_n_r   <= 1'b0;
                        end else begin
                            state_r <= ST_HOLD;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_READ_I: begin
                    if (ph_cnt_r == RD_LAST) begin
                        ibat_r    <= i_ADC_DATA;
                        valid_i_r <= 1'b1;
                        cs_i_n_r  <= 1'b1;
                        rd_n_r    <= 1'b1;
                        state_r   <= seen_v_r ? ST_GAP : ST_HOLD;
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_W'(1);
                    end
                end
                ST_GAP: begin
                    state_r  <= ST_READ_V;
                    cs_v_n_r <= 1'b0;
                    rd_n_r   <= 1'b0;
                    ph_cnt_r <= {PH_W{1'b0}};
                end
                ST_READ_V: begin
                    if (ph_cnt_r == RD_LAST) begin
                        vbat_r    <= i_ADC_DATA;
                        valid_v_r <= 1'b1;
                        cs_v_n_r  <= 1'b1;
                        rd_n_r    <= 1'b1;
                        state_r   <= ST_HOLD;
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_W'(1);
                    end
                end
                ST_HOLD: begin
                    // A counter already past the period means the sequence overran: restart at once
                    if (!i_enable) begin
                        state_r <= ST_IDLE;
                    end else if (per_cnt_r >= PER_LAST) begin
                        state_r    <= ST_CONV;
                        convst_n_r <= 1'b0;
                        per_cnt_r  <= {PER_W{1'b0}};
                        ph_cnt_r   <= {PH_W{1'b0}};
                        seen_i_r   <= 1'b0;
                        seen_v_r   <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    convst_n_r <= 1'b1;
                    cs_i_n_r   <= 1'b1;
                    cs_v_n_r   <= 1'b1;
                    rd_n_r     <= 1'b1;
                end
            endcase
        end
    end

    assign o_CONVST_n    = convst_n_r;
    assign o_CS_I_n      = cs_i_n_r;
    assign o_CS_V_n      = cs_v_n_r;
    assign o_RD_n        = rd_n_r;
    assign o_Ibat_ADC    = ibat_r;
    assign o_Vbat_ADC    = vbat_r;
    assign o_valid_I     = valid_i_r;
    assign o_valid_V     = valid_v_r;
    assign o_timeout_err = err_r;

endmodule

// File: tb/tb_rectifier_adc_sequencer.sv
// Scoreboard bench: an ADC responder model pushes the expected samples per conversion,
// a monitor pops them on each valid strobe. A second instance runs with a short period to force overruns.
module tb_rectifier_adc_sequencer;

    typedef struct packed {
        logic       ch;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n, en, clr, eoc_i_n, eoc_v_n;
    logic [7:0] adc_data;
    logic       convst_n, cs_i_n, cs_v_n, rd_n, vld_i, vld_v, terr;
    logic [7:0] ibat, vbat;

    logic       rst_b_n, en_b, eoc_b_n;
    logic [7:0] adc_data_b;
    logic       convst_b_n, cs_i_b_n, cs_v_b_n, rd_b_n, vld_i_b, vld_v_b, terr_b;
    logic [7:0] ibat_b, vbat_b;

    int         n_pass, n_total;
    int         cyc, seq_cnt, last_fall, overlap_a, overlap_b, b_falls;
    logic       last_fall_valid, err_exp, saw_err;
    int         cfg_di, cfg_dv;
    logic [7:0] cfg_ddi, cfg_ddv, lat_di, lat_dv;
    exp_t       exp_q[$];

    rectifier_adc_sequencer dut (
        .i_CLK(clk), .i_RST_n(rst_n), .i_enable(en), .i_err_clr(clr), .i_ADC_DATA(adc_data),
        .i_EOC_I_n(eoc_i_n), .i_EOC_V_n(eoc_v_n), .o_CONVST_n(convst_n), .o_CS_I_n(cs_i_n),
        .o_CS_V_n(cs_v_n), .o_RD_n(rd_n), .o_Ibat_ADC(ibat), .o_Vbat_ADC(vbat),
        .o_valid_I(vld_i), .o_valid_V(vld_v), .o_timeout_err(terr)
    );

    rectifier_adc_sequencer #(.SAMPLE_DIV(8)) dut_b (
        .i_CLK(clk), .i_RST_n(rst_b_n), .i_enable(en_b), .i_err_clr(1'b0), .i_ADC_DATA(adc_data_b),
        .i_EOC_I_n(eoc_b_n), .i_EOC_V_n(eoc_b_n), .o_CONVST_n(convst_b_n), .o_CS_I_n(cs_i_b_n),
        .o_CS_V_n(cs_v_b_n), .o_RD_n(rd_b_n), .o_Ibat_ADC(ibat_b), .o_Vbat_ADC(vbat_b),
        .o_valid_I(vld_i_b), .o_valid_V(vld_v_b), .o_timeout_err(terr_b)
    );

    // ADC data bus models: each device drives only while selected
    assign adc_data   = !cs_i_n ? lat_di : (!cs_v_n ? lat_dv : 8'hEE);
    assign adc_data_b = !cs_i_b_n ? 8'h3C : (!cs_v_b_n ? 8'hC3 : 8'hEE);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic pulse_eoc(input int d, input bit is_v);
        if (d >= 0) begin
            repeat (d) @(negedge clk);
            if (is_v) eoc_v_n = 1'b0; else eoc_i_n = 1'b0;
            repeat (2) @(negedge clk);
            if (is_v) eoc_v_n = 1'b1; else eoc_i_n = 1'b1;
        end
    endtask

    // ADC responder for the main DUT: latches the conversion setup and issues the expected samples
    initial begin : adc_a
        logic prev;
        int   low_cnt, cur_di, cur_dv;
        prev = 1'b1; low_cnt = 0; cur_di = -1; cur_dv = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b1;
                low_cnt = 0;
            end else begin
                if (prev && !convst_n) begin
                    cur_di = cfg_di; cur_dv = cfg_dv;
                    lat_di = cfg_ddi; lat_dv = cfg_ddv;
                    if (cur_di >= 0) exp_q.push_back({1'b0, cfg_ddi});
                    if (cur_dv >= 0) exp_q.push_back({1'b1, cfg_ddv});
                    if (last_fall_valid) check("convst_period", cyc - last_fall, 100);
                    last_fall = cyc;
                    last_fall_valid = 1'b1;
                    seq_cnt++;
                end
                if (!convst_n) low_cnt++;
                if (!prev && convst_n) begin
                    check("convst_width", low_cnt, 2);
                    low_cnt = 0;
                    fork
                        pulse_eoc(cur_di, 1'b0);
                        pulse_eoc(cur_dv, 1'b1);
                    join_none
                end
                prev = convst_n;
            end
        end
    end

    // Scoreboard monitor for the main DUT plus bus-protocol checks
    initial begin : mon_a
        int   run_i, run_v;
        logic pcs_i, pcs_v;
        exp_t e;
        run_i = 0; run_v = 0; pcs_i = 1'b1; pcs_v = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_i = 0; run_v = 0; pcs_i = 1'b1; pcs_v = 1'b1;
            end else begin
                if (terr) saw_err = 1'b1;
                if (!cs_i_n && !cs_v_n) overlap_a++;
                if (!rd_n && cs_i_n && cs_v_n) overlap_a++;
                if (!cs_i_n && !rd_n) run_i++;
                if (!cs_v_n && !rd_n) run_v++;
                if (!pcs_i && cs_i_n) begin check("rd_width_i", run_i, 3); run_i = 0; end
                if (!pcs_v && cs_v_n) begin check("rd_width_v", run_v, 3); run_v = 0; end
                if (vld_i) begin
                    check("valid_i_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("valid_i_channel", e.ch, 0);
                        check("ibat_data", ibat, e.data);
                    end
                end
                if (vld_v) begin
                    check("valid_v_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("valid_v_channel", e.ch, 1);
                        check("vbat_data", vbat, e.data);
                    end
                end
                pcs_i = cs_i_n; pcs_v = cs_v_n;
            end
        end
    end

    // EOC responder for the short-period instance: both converters finish right after CONVST rises
    initial begin : adc_b
        logic prev;
        prev = 1'b1; eoc_b_n = 1'b1;
        forever begin
            @(negedge clk);
            eoc_b_n = (rst_b_n && !prev && convst_b_n) ? 1'b0 : 1'b1;
            prev = convst_b_n;
        end
    end

    // Overrun monitor: back-to-back sequences, one sample per channel, no CS overlap
    initial begin : mon_b
        int   last, int0, csv_rise, nvi, nvv;
        logic pconv, pcsv;
        last = 0; int0 = 0; csv_rise = 0; nvi = 0; nvv = 0; pconv = 1'b1; pcsv = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_b_n) begin
                if (!cs_i_b_n && !cs_v_b_n) overlap_b++;
                if (!rd_b_n && cs_i_b_n && cs_v_b_n) overlap_b++;
                if (vld_i_b) begin nvi++; check("b_ibat", ibat_b, 8'h3C); end
                if (vld_v_b) begin nvv++; check("b_vbat", vbat_b, 8'hC3); end
                if (!pcsv && cs_v_b_n) csv_rise = cyc;
                if (pconv && !convst_b_n) begin
                    if (b_falls >= 1) begin
                        check("b_overrun", (cyc - last) > 8, 1);
                        check("b_hold_dwell", (cyc - csv_rise) <= 2, 1);
                        check("b_valid_i_count", nvi, 1);
                        check("b_valid_v_count", nvv, 1);
                    end
                    if (b_falls == 1) int0 = cyc - last;
                    if (b_falls >= 2) check("b_period_const", cyc - last, int0);
                    last = cyc; nvi = 0; nvv = 0;
                    b_falls++;
                end
                pconv = convst_b_n; pcsv = cs_v_b_n;
            end
        end
    end

    task automatic run_seq(input int di, input int dv, input logic [7:0] a, input logic [7:0] b);
        int t0;
        cfg_di = di; cfg_dv = dv; cfg_ddi = a; cfg_ddv = b;
        en = 1'b1;
        t0 = seq_cnt;
        for (int k = 0; k < 300 && seq_cnt == t0; k++) @(negedge clk);
        check("seq_start", seq_cnt != t0, 1);
        check("timeout_err", terr, err_exp);
        if (di < 0 || dv < 0) err_exp = 1'b1;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("err_clear", terr, 0);
        err_exp = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_convst"}, convst_n, 1);
        check({tag, "_cs_i"}, cs_i_n, 1);
        check({tag, "_cs_v"}, cs_v_n, 1);
        check({tag, "_rd"}, rd_n, 1);
        check({tag, "_ibat"}, ibat, 0);
        check({tag, "_vbat"}, vbat, 0);
        check({tag, "_valid"}, {vld_i, vld_v}, 0);
        check({tag, "_err"}, terr, 0);
    endtask

    function automatic int rnd_delay();
        if ($urandom_range(0, 4) == 0) return -1;
        return int'($urandom_range(1, 20));
    endfunction

    initial begin
        n_pass = 0; n_total = 0; seq_cnt = 0; last_fall = 0; overlap_a = 0; overlap_b = 0; b_falls = 0;
        last_fall_valid = 1'b0; err_exp = 1'b0; saw_err = 1'b0;
        rst_n = 1'b0; rst_b_n = 1'b0; en = 1'b0; en_b = 1'b0; clr = 1'b0;
        eoc_i_n = 1'b1; eoc_v_n = 1'b1;
        cfg_di = 10; cfg_dv = 10; cfg_ddi = 8'h5A; cfg_ddv = 8'hA5; lat_di = 8'h00; lat_dv = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1; rst_b_n = 1'b1; en_b = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal then randomized conversions
        run_seq(10, 10, 8'h5A, 8'hA5);
        run_seq(10, 10, 8'h5A, 8'hA5);
        for (int k = 0; k < 16; k++)
            run_seq(rnd_delay(), rnd_delay(), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        run_seq(10, 10, 8'h3C, 8'hC3);
        pulse_clr();

        // Missing V EOC: timeout flag, V sample retained, later clear
        run_seq(10, -1, 8'h11, 8'h22);
        run_seq(10, 10, 8'h33, 8'h44);
        check("timeout_ibat", ibat, 8'h11);
        check("timeout_vbat_kept", vbat, 8'hC3);
        pulse_clr();

        // Clear held across a timeout: set must win for at least one cycle
        run_seq(10, -1, 8'h55, 8'h66);
        clr = 1'b1; saw_err = 1'b0; err_exp = 1'b0;
        run_seq(10, 10, 8'h77, 8'h88);
        clr = 1'b0;
        check("set_wins_over_clear", saw_err, 1);

        // Enable dropped during READ_I: sequence completes, no further conversion
        begin
            int s0;
            run_seq(10, 10, 8'h99, 8'h66);
            for (int k = 0; k < 100 && cs_i_n; k++) @(negedge clk);
            check("reach_read_i", cs_i_n, 0);
            en = 1'b0;
            s0 = seq_cnt;
            repeat (300) @(negedge clk);
            check("no_convst_after_disable", seq_cnt, s0);
            check("disable_drain", exp_q.size(), 0);
            check("disable_convst_high", convst_n, 1);
            check("disable_vbat", vbat, 8'h66);
        end

        // Reset asserted during READ_V releases the bus immediately
        last_fall_valid = 1'b0;
        run_seq(10, 10, 8'hAB, 8'hCD);
        for (int k = 0; k < 100 && cs_v_n; k++) @(negedge clk);
        check("reach_read_v", cs_v_n, 0);
        #2 rst_n = 1'b0;
        en = 1'b0;
        #1 check_reset_state("midread_reset");
        exp_q.delete();
        err_exp = 1'b0;
        last_fall_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++)
            run_seq(rnd_delay(), rnd_delay(), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        run_seq(10, 10, 8'h12, 8'h34);
        en = 1'b0;
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
        check("final_drain", exp_q.size(), 0);
        check("cs_overlap_a", overlap_a, 0);
        check("cs_overlap_b", overlap_b, 0);
        check("b_seq_count", b_falls >= 5, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
